// File: rtl/otter_mem_pkg.sv
// Shared types for the cache-line memory adapter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package otter_mem_pkg;

  localparam int DEFAULT_BURST_LEN  = 32;
  localparam int DEFAULT_LINE_WIDTH = 256;

  typedef logic [DEFAULT_LINE_WIDTH-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_BEAT,
    WR_BEAT,
    GAP,
    DONE
  } adapter_state_t;

endpackage

// File: rtl/cacheline_mem_adapter.sv
// Splits one cache-line fill/writeback into BEATS single-beat memory transactions.
// Latency: 2*BEATS cycles from accept to the edge sampling line_resp, plus one per memory wait cycle.
// Backpressure: each beat holds until mem_resp; a per-beat timeout aborts the line with line_error.
module cacheline_mem_adapter
  import otter_mem_pkg::*;
#(
  parameter int BURST_LEN  = DEFAULT_BURST_LEN,
  parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    line_read,
  input  logic                    line_write,
  input  logic [31:0]             line_addr,
  input  logic [LINE_WIDTH-1:0]   line_wdata,
  output logic [LINE_WIDTH-1:0]   line_rdata,
  output logic                    line_resp,
  output logic                    line_error,
  output logic                    busy,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [31:0]             mem_address,
  output logic [BURST_LEN-1:0]    mem_wdata,
  output logic [BURST_LEN/8-1:0]  mem_byte_enable,
  input  logic                    mem_resp,
  input  logic [BURST_LEN-1:0]    mem_rdata
);

  localparam int BEATS = LINE_WIDTH / BURST_LEN;
  localparam int BYTES = BURST_LEN / 8;
  localparam int OFS   = $clog2(LINE_WIDTH / 8);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [31:0]   LINE_MASK = ~((32'd1 << OFS) - 32'd1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  // Last count value before the limit; the edge that sees it is the limit-th wait cycle.
  localparam logic [TW-1:0] TLAST     = TW'(TIMEOUT - 1);

  adapter_state_t          state;
  logic                    wr_txn;
  logic [31:0]             base;
  logic [LINE_WIDTH-1:0]   wbuf;
  logic [CW-1:0]           count;
  logic [TW-1:0]           tcnt;

  function automatic logic [31:0] beat_address(input logic [31:0] b, input logic [CW-1:0] c);
    return b + (32'(c) * 32'(BYTES));
  endfunction

  assign busy = (state != IDLE);

  // Line FSM: accepts requests in IDLE, sequences beats with a one-cycle gap, and reports in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      wr_txn          <= 1'b0;
      base            <= '0;
      wbuf            <= '0;
      count           <= '0;
      tcnt            <= '0;
      line_rdata      <= '0;
      line_resp       <= 1'b0;
      line_error      <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write wins when both are requested.
          if (line_write) begin
            wr_txn          <= 1'b1;
            base            <= line_addr & LINE_MASK;
            wbuf            <= line_wdata;
            count           <= '0;
            tcnt            <= '0;
            mem_write       <= 1'b1;
            mem_address     <= line_addr & LINE_MASK;
            mem_wdata       <= line_wdata[BURST_LEN-1:0];
            mem_byte_enable <= '1;
            state           <= WR_BEAT;
          end else if (line_read) begin
            wr_txn          <= 1'b0;
            base            <= line_addr & LINE_MASK;
            count           <= '0;
            tcnt            <= '0;
            line_rdata      <= '0;
            mem_read        <= 1'b1;
            mem_address     <= line_addr & LINE_MASK;
            mem_byte_enable <= '1;
            state           <= RD_BEAT;
          end
        end
        RD_BEAT, WR_BEAT: begin
          // A response on the limit cycle still wins over the timeout.
          if (mem_resp) begin
            if (state == RD_BEAT) begin
              line_rdata[int'(count)*BURST_LEN +: BURST_LEN] <= mem_rdata;
            end
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            tcnt            <= '0;
            if (count == LAST_BEAT) begin
              line_resp  <= 1'b1;
              line_error <= 1'b0;
              state      <= DONE;
            end else begin
              count <= count + CW'(1);
              state <= GAP;
            end
          end else if ((TIMEOUT != 0) && (tcnt == TLAST)) begin
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            line_resp       <= 1'b1;
            line_error      <= 1'b1;
            state           <= DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        GAP: begin
          tcnt            <= '0;
          mem_address     <= beat_address(base, count);
          mem_byte_enable <= '1;
          if (wr_txn) begin
            mem_write <= 1'b1;
            mem_wdata <= wbuf[int'(count)*BURST_LEN +: BURST_LEN];
            state     <= WR_BEAT;
          end else begin
            mem_read <= 1'b1;
            state    <= RD_BEAT;
          end
        end
        DONE: begin
          line_resp  <= 1'b0;
          line_error <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_mem_adapter.sv
// Scoreboarded bench for cacheline_mem_adapter with a behavioural memory.
// Latency: line latency is counted as the number of edges from accept to the edge sampling line_resp.
// Backpressure: memory inserts a programmable number of wait cycles per beat, or stalls one address.
module tb_cacheline_mem_adapter;

  localparam int BL    = 32;
  localparam int LW    = 256;
  localparam int TO    = 16;
  localparam int BEATS = LW / BL;

  logic            clk;
  logic            rst;
  logic            line_read;
  logic            line_write;
  logic [31:0]     line_addr;
  logic [LW-1:0]   line_wdata;
  logic [LW-1:0]   line_rdata;
  logic            line_resp;
  logic            line_error;
  logic            busy;
  logic            mem_read;
  logic            mem_write;
  logic [31:0]     mem_address;
  logic [BL-1:0]   mem_wdata;
  logic [BL/8-1:0] mem_byte_enable;
  logic            mem_resp;
  logic [BL-1:0]   mem_rdata;

  cacheline_mem_adapter #(.BURST_LEN(BL), .LINE_WIDTH(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write), .line_addr(line_addr),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .line_error(line_error), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          wr;
    bit          last;
  } beat_t;

  typedef struct {
    logic [LW-1:0] rdata;
    bit            err;
    int            lat;
  } line_exp_t;

  beat_t     beat_q[$];
  line_exp_t line_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory behaviour knobs.
  int          mem_wait   = 0;
  bit          spur       = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;

  // Monitor state.
  bit          in_beat = 0;
  beat_t       cur;
  int          post    = 0;
  int          wcnt    = 0;
  logic [69:0] snap;

  // Memory model and beat monitor: decides mem_resp for the next edge on every negedge.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    cur       = '{addr: 32'h0, wdata: 32'h0, wr: 1'b0, last: 1'b1};
    forever begin
      @(negedge clk);
      if (post == 1) begin
        check("gap_idle", {mem_read, mem_write, mem_byte_enable}, 0);
        post = cur.last ? 0 : 2;
      end else if (post == 2) begin
        check("gap_len", mem_read | mem_write, 1);
        post = 0;
      end
      if (mem_read || mem_write) begin
        if (!in_beat) begin
          in_beat = 1;
          wcnt    = 0;
          if (beat_q.size() == 0) begin
            check("beat_unexpected", 1, 0);
          end else begin
            cur = beat_q.pop_front();
            check("beat_type", {mem_read, mem_write}, {!cur.wr, cur.wr});
            check("beat_addr", mem_address, cur.addr);
            check("beat_be", mem_byte_enable, 4'hF);
            if (cur.wr) check("beat_wdata", mem_wdata, cur.wdata);
          end
          snap = {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable};
        end else begin
          check("beat_stable", {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable}, snap);
        end
        if (mem_address != stall_addr && wcnt == mem_wait) begin
          mem_resp  = 1'b1;
          mem_rdata = 32'h1000_0000 + mem_address;
          in_beat   = 0;
          post      = 1;
        end else begin
          mem_resp = 1'b0;
          wcnt++;
        end
      end else begin
        in_beat   = 0;
        mem_resp  = spur;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  function automatic logic [LW-1:0] rd_line(input logic [31:0] base, input int n);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < n; i++) l[i*BL +: BL] = 32'h1000_0000 + base + 32'(4 * i);
    return l;
  endfunction

  function automatic logic [LW-1:0] wr_line(input logic [31:0] pat);
    logic [LW-1:0] l;
    for (int i = 0; i < BEATS; i++) l[i*BL +: BL] = pat + 32'(i);
    return l;
  endfunction

  task automatic push_beats(input logic [31:0] base, input bit wr, input logic [LW-1:0] wd, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.addr  = base + 32'(4 * i);
      b.wdata = wd[i*BL +: BL];
      b.wr    = wr;
      b.last  = (i == n - 1);
      beat_q.push_back(b);
    end
  endtask

  task automatic push_line(input logic [LW-1:0] rd, input bit err, input int lat);
    line_exp_t e;
    e.rdata = rd;
    e.err   = err;
    e.lat   = lat;
    line_q.push_back(e);
  endtask

  // Issues one line request, waits (bounded) for line_resp and scores it.
  task automatic run_line(input bit rd, input bit wr, input logic [31:0] addr, input logic [LW-1:0] wd);
    int        lat;
    line_exp_t e;
    @(negedge clk);
    line_read  = rd;
    line_write = wr;
    line_addr  = addr;
    line_wdata = wd;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    while (!line_resp && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!line_resp) begin
      check("line_resp_timeout", 0, 1);
    end else if (line_q.size() == 0) begin
      check("line_resp_unexpected", 1, 0);
    end else begin
      e = line_q.pop_front();
      check("line_latency", lat + 1, e.lat);
      check("line_rdata", line_rdata, e.rdata);
      check("line_error", line_error, e.err);
      check("busy_in_done", busy, 1);
    end
    line_read  = 1'b0;
    line_write = 1'b0;
    @(negedge clk);
    check("resp_pulse", line_resp, 0);
    check("error_clear", line_error, 0);
    check("idle_after", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, line_rdata, 0);
    check({tag, "_resp"}, line_resp, 0);
    check({tag, "_error"}, line_error, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_rw"}, {mem_read, mem_write}, 0);
    check({tag, "_mem_addr"}, mem_address, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_be"}, mem_byte_enable, 0);
  endtask

  initial begin
    logic [LW-1:0] wd;
    logic [LW-1:0] last_rd;
    bit            found;
    rst        = 1'b0;
    line_read  = 1'b0;
    line_write = 1'b0;
    line_addr  = '0;
    line_wdata = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait read with unaligned address.
    mem_wait = 0;
    push_beats(32'h120, 1'b0, '0, BEATS);
    push_line(rd_line(32'h120, BEATS), 1'b0, 16);
    run_line(1'b1, 1'b0, 32'h0000_0124, '0);
    last_rd = rd_line(32'h120, BEATS);

    // Write with three wait cycles per beat; fill data must be untouched.
    mem_wait = 3;
    wd = wr_line(32'hA5A5_0000);
    push_beats(32'h2000, 1'b1, wd, BEATS);
    push_line(last_rd, 1'b0, 40);
    run_line(1'b0, 1'b1, 32'h0000_2000, wd);

    // Read and write together: write wins.
    mem_wait = 0;
    wd = wr_line(32'h5A5A_0000);
    push_beats(32'h3000, 1'b1, wd, BEATS);
    push_line(last_rd, 1'b0, 16);
    run_line(1'b1, 1'b1, 32'h0000_3000, wd);

    // Memory never answers beat 2: timeout after 16 wait cycles.
    stall_addr = 32'h308;
    push_beats(32'h300, 1'b0, '0, 3);
    push_line(rd_line(32'h300, 2), 1'b1, 21);
    run_line(1'b1, 1'b0, 32'h0000_0300, '0);
    stall_addr = 32'hFFFF_FFFF;

    // Reset during beat 5 of a write.
    mem_wait = 2;
    wd = wr_line(32'h7777_0000);
    push_beats(32'h4000, 1'b1, wd, 6);
    @(negedge clk);
    line_write = 1'b1;
    line_addr  = 32'h0000_4000;
    line_wdata = wd;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (mem_write && mem_address == 32'h4014) found = 1;
    end
    check("rst_beat5_seen", found, 1);
    #1 rst = 1'b0;
    #1 check_all_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_resp", line_resp, 0);
    end
    line_write = 1'b0;
    rst = 1'b1;
    check("beat_q_flushed", beat_q.size(), 0);

    // Normal read after reset, one wait cycle per beat.
    mem_wait = 1;
    push_beats(32'h500, 1'b0, '0, BEATS);
    push_line(rd_line(32'h500, BEATS), 1'b0, 24);
    run_line(1'b1, 1'b0, 32'h0000_0500, '0);
    last_rd = rd_line(32'h500, BEATS);

    // Spurious mem_resp while idle and in gaps.
    spur = 1;
    mem_wait = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("spur_idle_busy", busy, 0);
      check("spur_idle_resp", line_resp, 0);
      check("spur_idle_rdata", line_rdata, last_rd);
    end
    push_beats(32'h640, 1'b0, '0, BEATS);
    push_line(rd_line(32'h640, BEATS), 1'b0, 16);
    run_line(1'b1, 1'b0, 32'h0000_0650, '0);
    spur = 0;
    repeat (2) @(negedge clk);
    check("beats_all_seen", beat_q.size(), 0);
    check("lines_all_seen", line_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
